decoder_2_4_stream: RTL and testbench
=====================================

# decoder_2_4_stream

Registered, flow-controlled 2-to-4 decoder: the receive-side counterpart of the team's 4-to-2 encoder. It accepts a stream of encoded codes {valid-bit V, index Y[1:0]} and produces one-hot 4-bit words. Words are buffered in a small FIFO so the producer and consumer can stall independently. A saturating counter tracks how many "no active line" codes (V=0) have passed through, for debug visibility.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- CNT_W, 8: width of the no-line event counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  code present on in_v/in_y.
- in_ready  output  1  block can accept a code this cycle.
- in_v  input  1  encoder V bit; 1 = some line was active.
- in_y  input  2  encoder Y index.
- out_valid  output  1  out_d/out_none hold a decoded word.
- out_ready  input  1  consumer takes the word this cycle.
- out_d  output  4  one-hot decoded word; 4'b0000 when V=0.
- out_none  output  1  1 when the head word came from a V=0 code.
- cnt_clr  input  1  synchronous clear of cnt_none.
- cnt_none  output  CNT_W  saturating count of accepted V=0 codes.

## Operation
- Accept (push) when in_valid && in_ready. Deliver (pop) when out_valid && out_ready.
- Decode is computed at accept time:
  - in_v=1 gives out_d = 4'b0001 << in_y: 0→0001, 1→0010, 2→0100, 3→1000. out_none=0.
  - in_v=0 gives out_d = 4'b0000 and out_none=1; in_y is ignored.
- FIFO state:
  - Read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy count ranges 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
- Handshake outputs:
  - in_ready = !full. It depends on registered state only; there is no combinational path from out_ready.
  - out_valid = !empty. out_d/out_none always reflect the head entry.
- Push and pop in the same cycle leave the count unchanged and advance both pointers.
- When full, a pop frees a slot but in_ready stays low in that cycle. The push can happen the next cycle.
- A push while not in_ready is ignored. No state changes and cnt_none does not increment.
- Contents of out_d/out_none when out_valid=0 are don't-care for checking, but the RTL drives 0 for them.
- cnt_none:
  - Increments by 1 on each accepted V=0 code.
  - Saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr=1 forces 0 in that cycle. Clear wins over a simultaneous increment.
- Producer rule, checked by assertion: while in_valid=1 && in_ready=0, in_v/in_y must stay stable.
- Consumer rule, guaranteed by the block: out_d/out_none stay stable while out_valid=1 && out_ready=0.

## Timing
- Reset (rst_n=0, asynchronous) gives:
  - Pointers and count = 0, so out_valid=0 and in_ready=1.
  - out_d=4'b0000, out_none=0, cnt_none=0.
- While rst_n=0, all inputs are ignored.
- Reset asserted mid-stream discards all buffered words immediately. Deassertion is sampled synchronously; the first accept can occur on the first rising edge with rst_n=1.
- Latency: a code accepted into an empty FIFO at edge N appears with out_valid=1 after edge N. The consumer can take it at edge N+1.
- Throughput: 1 word/cycle sustained when out_ready is held high, for any DEPTH≥2.
- cnt_none updates on the same edge that accepts the V=0 code.

## Test plan
- Reset, then push codes {1,0},{1,1},{1,2},{1,3},{0,2} with out_ready=1. Required: out_d = 0001, 0010, 0100, 1000, 0000 in order; out_none=1 only on the last word; cnt_none=1.
- out_ready=0 with DEPTH=2, push 3 codes back-to-back. Required: in_ready drops after 2 accepts; the third code is held; out_d stays 0001 stable. Raise out_ready: the words drain in order, in_ready returns 1 the cycle after the first pop, and the third code is accepted.
- Full-rate streaming with in_valid=out_ready=1 for 20 cycles and random codes. Required: one word/cycle, and the output sequence equals the decoded input sequence delayed by 1 cycle.
- CNT_W=3, push 9 V=0 codes. Required: cnt_none reads 1..7 then stays 7. Assert cnt_clr in the same cycle as a 10th V=0 accept: cnt_none=0.
- Fill the FIFO with 2 words, then pulse rst_n low mid-cycle. Required: out_valid=0, in_ready=1, out_d=0000 and cnt_none=0 immediately, without waiting for a clock edge. After release, pushing {1,3} produces out_d=1000.
- Random in_valid/out_ready traffic, 10k cycles, against a scoreboard. Required: no loss, duplication or reorder; the count never exceeds DEPTH; output stability under stall is never violated.

Source files
------------

// File: rtl/decoder_2_4_stream.sv
// decoder_2_4_stream: registered 2-to-4 decoder with a small output FIFO.
// Decodes {in_v, in_y} to a one-hot word on accept and buffers it for the consumer.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, >= 2)
//   CNT_W    width of the saturating V=0 event counter
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready             producer handshake
//   in_v, in_y                    encoded code (valid bit, index)
//   out_valid/out_ready           consumer handshake
//   out_d, out_none               head word: one-hot value, no-line flag
//   cnt_clr, cnt_none             sync clear / saturating count of V=0 codes
module decoder_2_4_stream #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_v,
  input  logic [1:0]       in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_d,
  output logic             out_none,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_none
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  logic [3:0]       r_mem_d    [DEPTH];
  logic             r_mem_none [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_cnt;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_dec_d;
  logic       w_dec_none;

  // Handshake flags come from registered occupancy only.
  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  always_comb begin
    w_dec_d    = 4'b0000;
    w_dec_none = 1'b1;
    if (in_v) begin
      w_dec_none = 1'b0;
      unique case (in_y)
        2'd0: w_dec_d = 4'b0001;
        2'd1: w_dec_d = 4'b0010;
        2'd2: w_dec_d = 4'b0100;
        2'd3: w_dec_d = 4'b1000;
        default: w_dec_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_d[i]    <= 4'b0000;
        r_mem_none[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_mem_d[r_wptr]    <= w_dec_d;
      r_mem_none[r_wptr] <= w_dec_none;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_push && w_dec_none
                 && (r_cnt != L_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_d     = w_empty ? 4'b0000 : r_mem_d[r_rptr];
  assign out_none  = w_empty ? 1'b0 : r_mem_none[r_rptr];
  assign cnt_none  = r_cnt;

  a_prod_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (in_valid && !in_ready)
      |=> (!in_valid || $stable({in_v, in_y}))
  ) else $error("producer changed code while stalled");

  a_cons_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready)
      |=> (out_valid && $stable({out_d, out_none}))
  ) else $error("head word changed while stalled");

endmodule

// File: tb/tb_decoder_2_4_stream.sv
// tb_decoder_2_4_stream: scoreboard bench for decoder_2_4_stream.
// Directed scenarios followed by random traffic against a queue model.
module tb_decoder_2_4_stream;

  localparam int DEPTH = 2;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_v;
  logic [1:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_d;
  logic             out_none;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_none;

  decoder_2_4_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_v(in_v), .in_y(in_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_none(out_none),
    .cnt_clr(cnt_clr), .cnt_none(cnt_none)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expected words in order, plus a saturating counter.
  int q_d[$];
  int q_n[$];
  int m_cnt = 0;
  bit prev_stall = 0;
  int prev_d, prev_n;

  always @(negedge clk) begin
    int sz;
    bit acc;
    if (!rst_n) begin
      q_d.delete();
      q_n.delete();
      m_cnt = 0;
      prev_stall = 0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_cnt", int'(cnt_none), 0);
    end else begin
      sz = q_d.size();
      chk("out_valid", int'(out_valid), int'(sz != 0));
      chk("in_ready", int'(in_ready), int'(sz < DEPTH));
      chk("cnt_none", int'(cnt_none), m_cnt);
      if (out_valid && sz != 0) begin
        chk("out_d", int'(out_d), q_d[0]);
        chk("out_none", int'(out_none), q_n[0]);
      end
      if (prev_stall) begin
        chk("stall_d", int'(out_d), prev_d);
        chk("stall_none", int'(out_none), prev_n);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = int'(out_d);
      prev_n = int'(out_none);
      acc = in_valid && (sz < DEPTH);
      if (out_ready && sz != 0) begin
        void'(q_d.pop_front());
        void'(q_n.pop_front());
      end
      if (acc) begin
        q_d.push_back(in_v ? (1 << in_y) : 0);
        q_n.push_back(in_v ? 0 : 1);
      end
      if (cnt_clr) m_cnt = 0;
      else if (acc && !in_v && m_cnt < CMAX) m_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a code and hold it until accepted.
  task automatic send(input bit v, input int y);
    in_valid = 1'b1;
    in_v = v;
    in_y = 2'(y);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        cyc();
        in_valid = 1'b0;
        return;
      end
      cyc();
    end
    chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_v = 1'b0;
    in_y = 2'd0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    #2;
    chk("init_valid", int'(out_valid), 0);
    chk("init_ready", int'(in_ready), 1);
    chk("init_d", int'(out_d), 0);
    chk("init_none", int'(out_none), 0);
    chk("init_cnt", int'(cnt_none), 0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Basic decode of every index plus a no-line code.
    out_ready = 1'b1;
    send(1, 0);
    send(1, 1);
    send(1, 2);
    send(1, 3);
    send(0, 2);
    repeat (3) cyc();
    chk("cnt_after_basic", int'(cnt_none), 1);

    // Backpressure: third code held until a slot frees.
    out_ready = 1'b0;
    send(1, 0);
    send(1, 1);
    fork
      send(1, 2);
      begin
        repeat (3) cyc();
        chk("full_ready", int'(in_ready), 0);
        chk("full_head", int'(out_d), 1);
        out_ready = 1'b1;
      end
    join
    repeat (4) cyc();

    // Full-rate streaming.
    for (int i = 0; i < 20; i++)
      send(1'($urandom_range(0, 1)), $urandom_range(0, 3));
    repeat (3) cyc();

    // Counter saturation and clear priority.
    cnt_clr = 1'b1;
    cyc();
    cnt_clr = 1'b0;
    for (int i = 0; i < 9; i++) send(0, i % 4);
    chk("cnt_sat", int'(cnt_none), CMAX);
    cnt_clr = 1'b1;
    send(0, 1);
    cnt_clr = 1'b0;
    chk("cnt_clr_win", int'(cnt_none), 0);
    repeat (3) cyc();

    // Mid-cycle reset with a full FIFO.
    out_ready = 1'b0;
    send(1, 0);
    send(1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_ready", int'(in_ready), 1);
    chk("arst_d", int'(out_d), 0);
    chk("arst_cnt", int'(cnt_none), 0);
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1, 3);
    chk("post_rst_d", int'(out_d), 8);
    repeat (2) cyc();

    // Random traffic; producer holds a stalled code.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      cyc();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_v = ($urandom_range(0, 3) != 0);
        in_y = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cnt_clr = ($urandom_range(0, 63) == 0);
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
